wb_arb_queue_bank: RTL
======================

// Module: wb_arb_queue_bank
// PURPOSE
// - Parametrised successor to the single-pipe depth-1 execute->writeback buffer.
// - Gives each of p_num_pipes execute pipes a private FIFO of p_depth entries.
// - Arbitrates oldest-first onto one writeback port.
// - Purges squashed (younger-than-squash) entries in place, so execute units
//   never stall on writeback and mispredicted results never reach commit.
// PARAMETERS
// - p_num_pipes       4   number of execute pipes / input channels (>=1)
// - p_depth           2   entries per per-pipe FIFO (>=1; need not be a power of 2)
// - p_seq_num_bits    5   width of instruction sequence numbers
// - p_phys_addr_bits  6   width of physical destination register address
// PORTS
// - clk             in   1                  clock
// - rst             in   1                  reset, asynchronous, active-low
// - in_val          in   P                  per-pipe result valid
// - in_rdy          out  P                  per-pipe accept
// - in_pc           in   P x 32             per-pipe instruction PC
// - in_seq_num      in   P x p_seq_num_bits per-pipe sequence number
// - in_waddr        in   P x p_phys_addr_bits  per-pipe destination physical reg
// - in_wdata        in   P x 32             per-pipe result data
// - in_wen          in   P                  per-pipe register write enable
// - out_val         out  1                  writeback result valid
// - out_rdy         in   1                  writeback consumer accept
// - out_pc/out_seq_num/out_waddr/out_wdata/out_wen  out  widths as in_*  selected result
// - head_seq_num    in   p_seq_num_bits     seq num of oldest in-flight instruction (age base)
// - squash_val      in   1                  squash notification valid
// - squash_seq_num  in   p_seq_num_bits     seq num of the squashing instruction
// BEHAVIOUR
// - Reset (rst=0, async): all FIFOs empty, all entry live bits 0, pointers 0.
//   out_val=0; in_rdy=all 1s; out_* data = 0.
// - Age: age(s) = (s - head_seq_num) mod 2^p_seq_num_bits; smaller = older.
//   Younger(s) when age(s) > age(squash_seq_num).
// - Enqueue: per pipe, in_rdy[i] = !full[i], registered.
//   in_rdy has no combinational path from out_rdy or squash.
// - A full FIFO popped this cycle still shows in_rdy=0 this cycle.
// - Fire on in_val&in_rdy writes the tail entry, live=1. Latency: earliest out_val is the next cycle.
// - Squash (squash_val=1): every stored entry with Younger(seq) gets live=0 at the clock edge.
// - An input firing the same cycle with Younger(in_seq_num) is accepted (handshake completes).
//   It is then dropped and never written live.
// - The squashing instruction itself (age equal) is kept.
// - Dead-head drain: a FIFO whose head entry has live=0 pops it automatically.
//   Rate is one per FIFO per cycle, independent of out_rdy.
// - Arbitration (combinational over heads): candidates are FIFO heads with live=1.
//   A head is not a candidate if squash_val=1 this cycle and it is Younger.
//   The minimum-age candidate is selected; seq nums are unique, so there are no ties.
//   out_val = any candidate; out_* = selected head fields.
// - Output fire: out_val & out_rdy pops the selected FIFO.
//   out_* must hold stable while out_val=1 & out_rdy=0, unless a squash kills the shown entry.
// - Pointer wrap: head/tail increment to 0 after p_depth-1.
//   full/empty come from a count of 0..p_depth, not pointer equality.
// - Simultaneous enqueue+pop on one FIFO: count unchanged; legal when full only via the registered in_rdy rule above.
// - Entries in one FIFO are in-order by construction; no intra-FIFO reordering.
// - Reset mid-operation: all state cleared immediately; in-flight entries are lost.
//   No output fires in the reset cycle.
// STRUCTURE
// - Shared package (wb_pkg): typedef wb_entry_t {pc, seq_num, waddr, wdata, wen, live}.
//   Also holds an age() function and an is_younger(s, sq, head) function for reuse by the squash unit.
// - Sub-module wb_fifo_slot: one per pipe, generate-instantiated.
//   It holds the entry array, head/tail/count, the squash live-clear, and dead-head drain.
//   It exports head entry, head_live, in_rdy.
// - Top level: oldest-first selector tree over P heads, pop one-hot, output mux.
// TESTING
// - Reset check: assert rst=0 mid-stream with 3 entries queued.
//   Require out_val=0 at once and in_rdy=4'b1111 after release.
// - Oldest-first: pipes 0..3 enqueue seq 7,5,6,4 in one cycle, head_seq_num=4, out_rdy=1.
//   Require outputs in seq order 4,5,6,7 on 4 consecutive cycles.
// - Backpressure/full: p_depth=2; pipe 1 enqueues 3 results with out_rdy=0.
//   Require in_rdy[1]=0 after 2 fires; the 3rd is accepted only the cycle after the first pop.
// - Squash: queue seq 3,4,5,6 (head 3), then squash_seq_num=4.
//   Require seq 5 and 6 to never appear, 3 then 4 to be output, and a same-cycle input seq 9 to be accepted and dropped.
// - Wrap-around: head_seq_num=30, entries 31,0,1 (5-bit).
//   Require output order 31,0,1; a squash at 31 drops 0 and 1.
// - Stability: hold out_rdy=0 for 5 cycles with an older entry arriving.
//   Require out_* to be unchanged until the fire; then the older entry wins only if not yet shown.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and age helpers for the writeback arbitration queue bank.
// Entry fields are stored at a fixed maximum width so that one struct type
// serves every parameterisation. Modules zero-extend narrower fields into it.
package wb_pkg;

  localparam int unsigned WB_SEQ_MAX_W  = 16;
  localparam int unsigned WB_ADDR_MAX_W = 16;

  typedef struct packed {
    logic [31:0]              pc;
    logic [WB_SEQ_MAX_W-1:0]  seq_num;
    logic [WB_ADDR_MAX_W-1:0] waddr;
    logic [31:0]              wdata;
    logic                     wen;
    logic                     live;
  } wb_entry_t;

  // Distance of s from the oldest in-flight instruction, modulo 2^bits.
  function automatic logic [WB_SEQ_MAX_W-1:0] age(
    input logic [WB_SEQ_MAX_W-1:0] s,
    input logic [WB_SEQ_MAX_W-1:0] head,
    input int unsigned             bits
  );
    logic [WB_SEQ_MAX_W-1:0] mask;
    mask = (bits >= WB_SEQ_MAX_W) ? '1
         : ((WB_SEQ_MAX_W'(1) << bits) - WB_SEQ_MAX_W'(1));
    return (s - head) & mask;
  endfunction

  // True when s is strictly younger than the squashing instruction sq.
  function automatic logic is_younger(
    input logic [WB_SEQ_MAX_W-1:0] s,
    input logic [WB_SEQ_MAX_W-1:0] sq,
    input logic [WB_SEQ_MAX_W-1:0] head,
    input int unsigned             bits
  );
    return age(s, head, bits) > age(sq, head, bits);
  endfunction

endpackage

// File: rtl/wb_fifo_slot.sv
// Per-pipe result FIFO: count-based full/empty, in-place squash of younger
// entries, and automatic drain of a dead head independent of the consumer.
module wb_fifo_slot
  import wb_pkg::*;
#(
  parameter int unsigned p_depth        = 2,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_in_val,
  output logic                    o_in_rdy,
  input  wb_entry_t               i_in_entry,
  input  logic [WB_SEQ_MAX_W-1:0] i_head_seq,
  input  logic                    i_squash_val,
  input  logic [WB_SEQ_MAX_W-1:0] i_squash_seq,
  input  logic                    i_pop,
  output wb_entry_t               o_head,
  output logic                    o_head_live
);

  localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CNT_W = $clog2(p_depth + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(p_depth - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(p_depth);

  wb_entry_t        r_mem [p_depth];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_in_rdy;

  logic               w_enq;
  logic               w_deq;
  logic               w_nonempty;
  logic               w_head_live;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [p_depth-1:0] w_young;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // The entry's live bit already reflects a same-cycle squash, so a dropped
  // input still completes its handshake and occupies a slot as a dead entry.
  assign w_enq       = i_in_val & r_in_rdy;
  assign w_nonempty  = (r_count != '0);
  assign w_head_live = w_nonempty & r_mem[r_head].live;
  assign w_deq       = w_nonempty & (~r_mem[r_head].live | i_pop);
  assign w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
  assign o_in_rdy    = r_in_rdy;
  assign o_head_live = w_head_live;

  // Flag every stored entry younger than the squashing instruction.
  always_comb begin
    w_young = '0;
    for (int k = 0; k < int'(p_depth); k++) begin
      w_young[k] = i_squash_val &&
                   is_younger(r_mem[k].seq_num, i_squash_seq, i_head_seq, p_seq_num_bits);
    end
  end

  // Present the head with its live bit qualified by occupancy.
  always_comb begin
    o_head      = r_mem[r_head];
    o_head.live = w_head_live;
  end

  // Pointers, count, registered ready and live bits; payload fields are not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_in_rdy <= 1'b1;
      for (int k = 0; k < int'(p_depth); k++) begin
        r_mem[k].live <= 1'b0;
      end
    end else begin
      for (int k = 0; k < int'(p_depth); k++) begin
        if (w_young[k]) begin
          r_mem[k].live <= 1'b0;
        end
      end
      if (w_enq) begin
        r_mem[r_tail] <= i_in_entry;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_deq) begin
        r_head <= ptr_inc(r_head);
      end
      r_count  <= w_count_nxt;
      r_in_rdy <= (w_count_nxt != FULL);
    end
  end

endmodule

// File: rtl/wb_arb_queue_bank.sv
// Writeback queue bank: one FIFO per execute pipe, oldest-first arbitration
// of live heads onto a single writeback port, with squash purging.
// A shown-but-stalled selection is locked so out_* stays stable until it
// fires or is squashed; newly arriving older results wait behind it.
module wb_arb_queue_bank
  import wb_pkg::*;
#(
  parameter int unsigned p_num_pipes      = 4,
  parameter int unsigned p_depth          = 2,
  parameter int unsigned p_seq_num_bits   = 5,
  parameter int unsigned p_phys_addr_bits = 6
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [p_num_pipes-1:0]                           in_val,
  output logic [p_num_pipes-1:0]                           in_rdy,
  input  logic [p_num_pipes-1:0][31:0]                     in_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]       in_seq_num,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     in_waddr,
  input  logic [p_num_pipes-1:0][31:0]                     in_wdata,
  input  logic [p_num_pipes-1:0]                           in_wen,
  output logic                                             out_val,
  input  logic                                             out_rdy,
  output logic [31:0]                                      out_pc,
  output logic [p_seq_num_bits-1:0]                        out_seq_num,
  output logic [p_phys_addr_bits-1:0]                      out_waddr,
  output logic [31:0]                                      out_wdata,
  output logic                                             out_wen,
  input  logic [p_seq_num_bits-1:0]                        head_seq_num,
  input  logic                                             squash_val,
  input  logic [p_seq_num_bits-1:0]                        squash_seq_num
);

  localparam int unsigned P = p_num_pipes;

  logic [WB_SEQ_MAX_W-1:0] w_base_seq;
  logic [WB_SEQ_MAX_W-1:0] w_sq_seq;
  wb_entry_t               w_head [P];
  logic [WB_SEQ_MAX_W-1:0] w_age  [P];
  logic [P-1:0]            w_head_live;
  logic [P-1:0]            w_cand;
  logic [P-1:0]            w_arb_oh;
  logic [P-1:0]            w_lock_oh;
  logic [P-1:0]            w_sel_oh;
  logic [P-1:0]            w_pop;
  logic [P-1:0]            r_lock_oh;
  wb_entry_t               w_out;
  logic                    w_unused_out;

  assign w_base_seq = WB_SEQ_MAX_W'(head_seq_num);
  assign w_sq_seq   = WB_SEQ_MAX_W'(squash_seq_num);

  for (genvar g = 0; g < P; g++) begin : g_pipe
    wb_entry_t w_in_entry;

    // Widen the incoming result and mark it dead if a same-cycle squash covers it.
    always_comb begin
      w_in_entry         = '0;
      w_in_entry.pc      = in_pc[g];
      w_in_entry.seq_num = WB_SEQ_MAX_W'(in_seq_num[g]);
      w_in_entry.waddr   = WB_ADDR_MAX_W'(in_waddr[g]);
      w_in_entry.wdata   = in_wdata[g];
      w_in_entry.wen     = in_wen[g];
      w_in_entry.live    = !(squash_val &&
                             is_younger(w_in_entry.seq_num, w_sq_seq, w_base_seq, p_seq_num_bits));
    end

    wb_fifo_slot #(
      .p_depth       (p_depth),
      .p_seq_num_bits(p_seq_num_bits)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst),
      .i_in_val    (in_val[g]),
      .o_in_rdy    (in_rdy[g]),
      .i_in_entry  (w_in_entry),
      .i_head_seq  (w_base_seq),
      .i_squash_val(squash_val),
      .i_squash_seq(w_sq_seq),
      .i_pop       (w_pop[g]),
      .o_head      (w_head[g]),
      .o_head_live (w_head_live[g])
    );

    // A head being squashed this cycle is withheld so it cannot fire.
    assign w_cand[g] = w_head_live[g] &&
                       !(squash_val && is_younger(w_head[g].seq_num, w_sq_seq, w_base_seq, p_seq_num_bits));
    assign w_age[g]  = age(w_head[g].seq_num, w_base_seq, p_seq_num_bits);
  end

  // Pairwise age comparison: a candidate wins when no other candidate is older.
  always_comb begin
    w_arb_oh = '0;
    for (int i = 0; i < int'(P); i++) begin
      w_arb_oh[i] = w_cand[i];
      for (int j = 0; j < int'(P); j++) begin
        if ((j != i) && w_cand[j] && (w_age[j] < w_age[i])) begin
          w_arb_oh[i] = 1'b0;
        end
      end
    end
  end

  // A still-valid locked head overrides fresh arbitration to keep out_* stable.
  assign w_lock_oh = r_lock_oh & w_cand;
  assign w_sel_oh  = (|w_lock_oh) ? w_lock_oh : w_arb_oh;
  assign out_val   = |w_cand;
  assign w_pop     = w_sel_oh & {P{out_rdy}};

  // One-hot output mux; all zeros when nothing is selected.
  always_comb begin
    w_out = '0;
    for (int i = 0; i < int'(P); i++) begin
      if (w_sel_oh[i]) begin
        w_out = w_head[i];
      end
    end
  end

  assign out_pc       = w_out.pc;
  assign out_seq_num  = w_out.seq_num[p_seq_num_bits-1:0];
  assign out_waddr    = w_out.waddr[p_phys_addr_bits-1:0];
  assign out_wdata    = w_out.wdata;
  assign out_wen      = w_out.wen;
  assign w_unused_out = ^{w_out.seq_num, w_out.waddr, w_out.live};

  // Remember which head is on display while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock_oh <= '0;
    end else begin
      r_lock_oh <= (out_val && !out_rdy) ? w_sel_oh : '0;
    end
  end

endmodule
